// File: rtl/psum_pkg.sv
// Shared constants and pipeline op type for the partial-sum scratchpad.
package psum_pkg;

  localparam int IN_W_D   = 8;
  localparam int PSUM_W_D = 16;
  localparam int DEPTH_D  = 64;
  localparam int ADDR_W_D = $clog2(DEPTH_D);
  localparam int STAGES   = 2;

  localparam logic [PSUM_W_D-1:0] PSUM_MAX = {1'b0, {(PSUM_W_D-1){1'b1}}};
  localparam logic [PSUM_W_D-1:0] PSUM_MIN = {1'b1, {(PSUM_W_D-1){1'b0}}};

  typedef struct packed {
    logic                acc;
    logic [ADDR_W_D-1:0] addr;
    logic [PSUM_W_D-1:0] data;
  } psum_op_t;

endpackage

// File: rtl/psum_acc_alu.sv
// Combinational sign-extend and accumulate/pass with signed overflow detect.
// PSUM_SAT_EN: clamp overflowing accumulates instead of wrapping.
module psum_acc_alu
  import psum_pkg::*;
#(
  parameter int IN_W   = IN_W_D,
  parameter int PSUM_W = PSUM_W_D
) (
  input  logic [IN_W-1:0]   in_data,
  output logic [PSUM_W-1:0] ext,
  input  logic              acc,
  input  logic [PSUM_W-1:0] old,
  input  logic [PSUM_W-1:0] operand,
  output logic [PSUM_W-1:0] res,
  output logic              ovf
);

  localparam int MSB = PSUM_W - 1;
  localparam logic [PSUM_W-1:0] SMAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] SMIN = {1'b1, {(PSUM_W-1){1'b0}}};

  logic [PSUM_W-1:0] sum;

  assign ext = PSUM_W'($signed(in_data));

  always_comb begin
    sum = old + operand;
    ovf = acc & (old[MSB] == operand[MSB]) & (sum[MSB] != operand[MSB]);
    res = acc ? sum : operand;
`ifdef PSUM_SAT_EN
    // Both operands share a sign on overflow, so the operand sign picks the rail.
    if (ovf) res = operand[MSB] ? SMIN : SMAX;
`else
    if (ovf) res = sum;
`endif
  end

endmodule

// File: rtl/psum_spad_acc.sv
// Partial-sum scratchpad: two-stage RMW write pipe with forwarding, registered
// read port, valid-bit clear, sticky overflow. PSUM_SAT_EN selects saturation.
module psum_spad_acc
  import psum_pkg::*;
#(
  parameter int IN_W   = IN_W_D,
  parameter int PSUM_W = PSUM_W_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              wr_acc,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IN_W-1:0]   wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PSUM_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ovf
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [PSUM_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [STAGES:1]   vld_pipe;

  psum_op_t          s1;
  logic [PSUM_W-1:0] s1_old;
  logic [ADDR_W-1:0] s2_addr;
  logic [PSUM_W-1:0] s2_data;

  logic [PSUM_W-1:0] wr_ext, old, alu_res;
  logic              alu_ovf, wr_ok, rd_ok, commit;

  assign wr_ok  = wr_en & ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok  = {1'b0, rd_addr} < DEPTH_L;
  assign commit = vld_pipe[1] & ~clr;

  // s1_old was sampled at the same edge S2 committed; forward that commit if it hit us.
  assign old = (vld_pipe[2] && (s2_addr == s1.addr)) ? s2_data : s1_old;

  psum_acc_alu #(.IN_W(IN_W), .PSUM_W(PSUM_W)) u_alu (
    .in_data (wr_data),
    .ext     (wr_ext),
    .acc     (s1.acc),
    .old     (old),
    .operand (s1.data),
    .res     (alu_res),
    .ovf     (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ent_vld  <= '0;
      s1       <= '0;
      s1_old   <= '0;
      s2_addr  <= '0;
      s2_data  <= '0;
      ovf      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (rd_ok && ent_vld[rd_addr]) ? mem[rd_addr] : '0;

      if (clr) begin
        vld_pipe <= '0;
        ent_vld  <= '0;
        ovf      <= 1'b0;
      end else begin
        vld_pipe <= {vld_pipe[1], wr_ok};
        if (wr_ok) begin
          s1     <= '{acc: wr_acc, addr: wr_addr, data: wr_ext};
          s1_old <= ent_vld[wr_addr] ? mem[wr_addr] : '0;
        end
        if (commit) begin
          ent_vld[s1.addr] <= 1'b1;
          s2_addr          <= s1.addr;
          s2_data          <= alu_res;
          ovf              <= ovf | alu_ovf;
        end
      end
    end
  end

  // Storage array has no reset; validity is tracked by ent_vld.
  always_ff @(posedge clk) begin
    if (commit) mem[s1.addr] <= alu_res;
  end

endmodule

// File: tb/tb_psum_spad_acc.sv
// Directed bench for psum_spad_acc; expectations follow the PSUM_SAT_EN build.
module tb_psum_spad_acc;
  import psum_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic        wr_en = 1'b0, wr_acc = 1'b0, rd_en = 1'b0;
  logic [5:0]  wr_addr = '0, rd_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [15:0] rd_data;
  logic        rd_valid, ovf;
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  psum_spad_acc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_acc   (wr_acc),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ovf      (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One write request for one edge; back-to-back calls give one per cycle.
  task automatic wr(input logic acc, input logic [5:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_acc = acc; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = a;
    step();
    chk(tag, rd_data, exp);
    chk({tag, "_vld"}, {15'b0, rd_valid}, 16'd1);
    rd_en = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) step();
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_rd_valid", {15'b0, rd_valid}, 16'd0);
    chk("rst_ovf", {15'b0, ovf}, 16'd0);
    rst_n = 1'b1;
    step();
    rd(6'd5, 16'h0000, "rst_read5");
    chk("rst_ovf_after", {15'b0, ovf}, 16'd0);
    step();
    chk("rd_valid_pulse", {15'b0, rd_valid}, 16'd0);

    // overwrite 5 then accumulate -2 back-to-back: 3
    wr(1'b0, 6'd3, 8'h05);
    wr(1'b1, 6'd3, 8'hFE);
    step();
    rd(6'd3, 16'h0003, "ow_then_acc");

    // three +1 accumulates from empty through forwarding
    repeat (3) wr(1'b1, 6'd7, 8'h01);
    step();
    rd(6'd7, 16'h0003, "acc_x3");

    // 127 * 258 = 32766 stays in range; one more 127 overflows
    wr(1'b0, 6'd1, 8'h7F);
    repeat (257) wr(1'b1, 6'd1, 8'h7F);
    step();
    chk("ovf_pre", {15'b0, ovf}, 16'd0);
    rd(6'd1, 16'h7FFE, "pre_ovf_sum");
    wr(1'b1, 6'd1, 8'h7F);
    step();
    chk("ovf_set", {15'b0, ovf}, 16'd1);
`ifdef PSUM_SAT_EN
    rd(6'd1, PSUM_MAX, "pos_ovf_val");
`else
    rd(6'd1, 16'h807D, "pos_ovf_val");
`endif

    // clr with a same-cycle write and read, plus an in-flight write to addr 6
    wr(1'b0, 6'd2, 8'h09);
    step();
    wr(1'b0, 6'd6, 8'h11);
    clr = 1'b1;
    wr_en = 1'b1; wr_acc = 1'b0; wr_addr = 6'd2; wr_data = 8'h55;
    rd_en = 1'b1; rd_addr = 6'd2;
    step();
    chk("clr_rd_preclear", rd_data, 16'h0009);
    chk("clr_ovf", {15'b0, ovf}, 16'd0);
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) step();
    rd(6'd2, 16'h0000, "clr_drop_wr");
    rd(6'd6, 16'h0000, "clr_drop_inflight");
    rd(6'd1, 16'h0000, "clr_invalidate");

    // overwrite with a negative value: sign-extended, no ovf
    wr(1'b0, 6'd2, 8'h80);
    step();
    chk("ow_no_ovf", {15'b0, ovf}, 16'd0);
    rd(6'd2, 16'hFF80, "sext_neg");

    // read during the commit edge sees old, next read sees new, then hold
    wr(1'b0, 6'd4, 8'h02);
    step();
    wr(1'b0, 6'd4, 8'h06);
    rd_en = 1'b1; rd_addr = 6'd4;
    step();
    chk("rd_during_commit", rd_data, 16'h0002);
    step();
    chk("rd_after_commit", rd_data, 16'h0006);
    rd_en = 1'b0;
    step();
    chk("rd_hold", rd_data, 16'h0006);
    chk("rd_idle_valid", {15'b0, rd_valid}, 16'd0);

    // -128 * 256 = -32768 exactly, no ovf; one more -128 overflows
    wr(1'b0, 6'd10, 8'h80);
    repeat (255) wr(1'b1, 6'd10, 8'h80);
    step();
    chk("min_no_ovf", {15'b0, ovf}, 16'd0);
    rd(6'd10, PSUM_MIN, "min_exact");
    wr(1'b1, 6'd10, 8'h80);
    step();
    chk("neg_ovf_set", {15'b0, ovf}, 16'd1);
`ifdef PSUM_SAT_EN
    rd(6'd10, PSUM_MIN, "neg_ovf_val");
`else
    rd(6'd10, 16'h7F80, "neg_ovf_val");
`endif

    // async reset in the middle of a write/read burst
    wr_en = 1'b1; wr_acc = 1'b1; wr_addr = 6'd8; wr_data = 8'h01;
    rd_en = 1'b1; rd_addr = 6'd4;
    repeat (2) step();
    chk("burst_rd", rd_data, 16'h0006);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd_data", rd_data, 16'h0000);
    chk("async_rst_rd_valid", {15'b0, rd_valid}, 16'd0);
    chk("async_rst_ovf", {15'b0, ovf}, 16'd0);
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    rd(6'd8, 16'h0000, "rst_drop_burst");
    rd(6'd4, 16'h0000, "rst_invalidate");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
